// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider
// sharing one hi/lo datapath, fixed WIDTH-edge latency for every op.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       rd_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rd_out
);

    localparam int unsigned    CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_op;
    logic [4:0]       r_rd;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic             r_neg;
    logic             r_rneg;

    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_hi_n;
    logic [WIDTH-1:0] w_lo_n;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_sprod;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_remf;
    logic [WIDTH-1:0] w_result;

    always_comb begin
        w_sa    = (op == OP_MUL || op == OP_MULH || op == OP_MULHSU ||
                   op == OP_DIV || op == OP_REM) && a[WIDTH-1];
        w_sb    = (op == OP_MUL || op == OP_MULH || op == OP_DIV || op == OP_REM) && b[WIDTH-1];
        w_mag_a = w_sa ? -a : a;
        w_mag_b = w_sb ? -b : b;

        // Multiply: conditional add into hi, then shift {hi,lo} right one bit.
        w_sum   = {1'b0, r_hi} + {1'b0, r_b & {WIDTH{r_lo[0]}}};
        // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
        w_shift = {r_hi, r_lo[WIDTH-1]};
        w_ge    = w_shift >= {1'b0, r_b};
        w_rem   = w_ge ? (w_shift[WIDTH-1:0] - r_b) : w_shift[WIDTH-1:0];

        if (r_op[2]) begin
            w_hi_n = w_rem;
            w_lo_n = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            w_hi_n = w_sum[WIDTH:1];
            w_lo_n = {w_sum[0], r_lo[WIDTH-1:1]};
        end

        w_prod  = {w_hi_n, w_lo_n};
        w_sprod = r_neg ? -w_prod : w_prod;
        w_quo   = r_neg ? -w_lo_n : w_lo_n;
        w_remf  = r_rneg ? -w_hi_n : w_hi_n;

        case (r_op)
            OP_MUL:                        w_result = w_sprod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_result = w_sprod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:               w_result = w_quo;
            default:                       w_result = w_remf;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_rd    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_b     <= '0;
            r_neg   <= 1'b0;
            r_rneg  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            rd_out  <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_state <= CALC;
                        busy    <= 1'b1;
                        r_cnt   <= '0;
                        r_op    <= op;
                        r_rd    <= rd_in;
                        r_hi    <= '0;
                        r_lo    <= w_mag_a;
                        r_b     <= w_mag_b;
                        // Divide by zero keeps the all-ones quotient unsigned.
                        r_neg   <= op[2] ? ((w_sa ^ w_sb) & (|b)) : (w_sa ^ w_sb);
                        r_rneg  <= w_sa;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    r_hi  <= w_hi_n;
                    r_lo  <= w_lo_n;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        result  <= w_result;
                        rd_out  <= r_rd;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, handshake, signed/unsigned
// results, RISC-V divide special cases, reset abort and back-to-back start.
module tb_muldiv_unit;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  rd_in = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] last_res = '0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive a request so that the next rising edge is E0, then scramble the inputs.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] r);
        op = o; a = x; b = y; rd_in = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 3'($urandom); rd_in = 5'($urandom);
    endtask

    // Step E1..E32; busy must be steady with result held, done only after E32.
    task automatic run_calc(input string tag, input logic [31:0] exp, input logic [4:0] r,
                            input bit pulse);
        bit ok;
        ok = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            @(posedge clk); #1;
            if (e < 32 && !(busy === 1'b1 && done === 1'b0 && result === last_res))
                ok = 1'b0;
            if (pulse && e == 4) begin
                start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd10; rd_in = 5'd31;
            end
            if (pulse && e == 5)
                start = 1'b0;
        end
        check({tag, " calc"}, {31'b0, ok}, 32'h1);
        check({tag, " busy/done"}, {30'b0, busy, done}, 32'h1);
        check({tag, " result"}, result, exp);
        check({tag, " rd_out"}, {27'b0, rd_out}, {27'b0, r});
        last_res = exp;
    endtask

    task automatic settle(input string tag);
        @(posedge clk); #1;
        check({tag, " done drop"}, {30'b0, busy, done}, 32'h0);
        check({tag, " hold"}, result, last_res);
    endtask

    task automatic op_test(input string tag, input logic [2:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [4:0] r, input logic [31:0] exp);
        issue(o, x, y, r);
        run_calc(tag, exp, r, 1'b0);
        settle(tag);
    endtask

    initial begin
        bit saw_done;

        repeat (2) @(posedge clk);
        #1;
        check("reset busy/done", {30'b0, busy, done}, 32'h0);
        check("reset result", result, 32'h0);
        check("reset rd_out", {27'b0, rd_out}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        op_test("MUL 7*-3", OP_MUL, 32'd7, 32'hFFFFFFFD, 5'd9, 32'hFFFFFFEB);
        op_test("MULH min*min", OP_MULH, 32'h80000000, 32'h80000000, 5'd1, 32'h40000000);
        op_test("MULHU max*max", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE);
        op_test("MULHSU -1*2 rd0", OP_MULHSU, 32'hFFFFFFFF, 32'd2, 5'd0, 32'hFFFFFFFF);
        op_test("DIV -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd3, 32'hFFFFFFFD);
        op_test("REM -7/2", OP_REM, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFF);
        op_test("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14);
        op_test("REMU 100/7", OP_REMU, 32'd100, 32'd7, 5'd6, 32'd2);
        op_test("DIV 5/0", OP_DIV, 32'd5, 32'd0, 5'd7, 32'hFFFFFFFF);
        op_test("DIV -5/0", OP_DIV, 32'hFFFFFFFB, 32'd0, 5'd8, 32'hFFFFFFFF);
        op_test("REMU 5/0", OP_REMU, 32'd5, 32'd0, 5'd10, 32'd5);
        op_test("REM -5/0", OP_REM, 32'hFFFFFFFB, 32'd0, 5'd11, 32'hFFFFFFFB);
        op_test("DIV ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000);
        op_test("REM ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000);

        // start pulsed during CALC must not disturb the running divide
        issue(OP_DIVU, 32'd100, 32'd7, 5'd14);
        run_calc("start in CALC", 32'd14, 5'd14, 1'b1);
        settle("start in CALC");

        // start held through DONE launches the next op with no idle cycle
        issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15);
        run_calc("chain first", 32'hFFFFFFFE, 5'd15, 1'b0);
        op = OP_DIVU; a = 32'd9; b = 32'd3; rd_in = 5'd16; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        check("chain restart", {30'b0, busy, done}, 32'h2);
        run_calc("chain second", 32'd3, 5'd16, 1'b0);
        settle("chain second");

        // asynchronous reset at E10 of a multiply aborts it
        issue(OP_MUL, 32'd1234, 32'd5678, 5'd17);
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort busy/done", {30'b0, busy, done}, 32'h0);
        check("abort result", result, 32'h0);
        check("abort rd_out", {27'b0, rd_out}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        check("abort no done", {31'b0, saw_done}, 32'h0);
        last_res = '0;
        op_test("MULHU 3*5 post reset", OP_MULHU, 32'd3, 32'd5, 5'd18, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Consumes the two register-file read operands (RD1/RD2) and an op code. Produces a 32-bit result plus destination register index, which drive the register-file write port (WD3/A3/WE3).
- Fixed-latency shift-add multiplier and restoring divider sharing one datapath. The controller stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32: operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (rst=0 resets).
- start  input  1  request; sampled on a rising edge when state is IDLE or DONE.
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  WIDTH  operand rs1 (from RD1).
- b  input  WIDTH  operand rs2 (from RD2).
- rd_in  input  5  destination register index.
- busy  output  1  high while iterating (CALC).
- done  output  1  one-cycle pulse, result valid (feeds WE3).
- result  output  WIDTH  result (feeds WD3).
- rd_out  output  5  captured rd_in (feeds A3).

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - State goes to IDLE.
  - busy=0, done=0, result=0, rd_out=0.
  - Counter and internal registers are cleared.
  - Any in-flight operation is discarded, with no done pulse.
- States and transitions:
  - IDLE -> CALC on start=1.
  - CALC -> DONE after WIDTH iterations.
  - DONE -> CALC if start=1, else DONE -> IDLE.
- Outputs per state:
  - IDLE: busy=0, done=0.
  - CALC: busy=1, done=0.
  - DONE: busy=0, done=1.
- Capture (edge E0, start accepted):
  - Latch op and rd_in.
  - Latch operand magnitudes and result sign.
  - Load counter to 0.
  - a, b, op and rd_in may change freely after E0.
- Iteration and latency:
  - Edges E1..E32 each perform one iteration (one partial product or one quotient bit).
  - At E32 the final signed/selected result is registered and the state moves to DONE.
  - done is high for exactly the cycle between E32 and E33.
  - Latency is fixed at 32 edges for every op, including special cases.
- start while in CALC is ignored; the operation in progress is unaffected.
- Output holding:
  - result and rd_out hold their value after DONE until the next DONE.
  - They do not change during CALC.
- Signedness:
  - Signed operands are converted to magnitude; the core works unsigned; a conditional two's-complement fixes the sign at the end.
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Multiply:
  - 64-bit product.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- Divide:
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
  - Quotient truncates toward zero.
- Special cases (RISC-V, no trap):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
- rd_out=0 still produces done. Suppressing the x0 write is the register file's job.

Test Plan:
- Reset rst=0 mid-op at E10 -> busy=0, done=0, result=0 immediately (before next edge); no done appears. Release, then MULHU 3*5 -> result 0, done at E32.
- MUL a=7, b=0xFFFFFFFD, rd_in=9 -> busy=1 over E1..E32; done=1 only in the cycle after E32; result=0xFFFFFFEB; rd_out=9.
- MULH 0x80000000*0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- start pulsed at E5 in CALC -> ignored, first result unchanged.
- start held during DONE with DIVU 9/3 -> new CALC begins immediately, done again 32 edges later with 3.
